// File: rtl/out_seq_pkg.sv
// rtl/out_seq_pkg.sv - states, config addresses and channel indices for the output pattern sequencer
package out_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam logic [3:0] ADDR_CH0    = 4'd0;
    localparam logic [3:0] ADDR_CH1    = 4'd1;
    localparam logic [3:0] ADDR_CH2    = 4'd2;
    localparam logic [3:0] ADDR_CH3    = 4'd3;
    localparam logic [3:0] ADDR_CH4    = 4'd4;
    localparam logic [3:0] ADDR_CH5    = 4'd5;
    localparam logic [3:0] ADDR_CH6    = 4'd6;
    localparam logic [3:0] ADDR_CH7    = 4'd7;
    localparam logic [3:0] ADDR_PERIOD = 4'd8;
    localparam logic [3:0] ADDR_FCOUNT = 4'd9;
    localparam logic [3:0] ADDR_POL    = 4'd10;

    // fall field sits in the upper half of a channel window write
    localparam int FALL_LSB = 16;

    localparam int CH_CLK_P      = 0;
    localparam int CH_CLK_SHORT  = 1;
    localparam int CH_CLK_D      = 2;
    localparam int CH_CLK_DAC    = 3;
    localparam int CH_CLK_DAC_P  = 4;
    localparam int CH_CLK_DAC_D  = 5;
    localparam int CH_RST        = 6;
    localparam int CH_STIM       = 7;

endpackage

// File: rtl/out_seq_channel.sv
// rtl/out_seq_channel.sv - one drive channel: rise/fall window registers and registered window compare
module out_seq_channel
    import out_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk_in_500MHz,
    input  logic             reset_n,
    input  logic             i_cfg_we,
    input  logic [31:0]      i_cfg_wdata,
    input  logic [CNT_W-1:0] i_phase,
    input  logic             i_run_en,
    input  logic             i_inv,
    output logic             o_level
);

    logic [CNT_W-1:0] r_rise;
    logic [CNT_W-1:0] r_fall;
    logic             r_level;
    logic             w_window;

    // an empty or inverted window (rise >= fall) never drives
    assign w_window = (r_rise < r_fall) && (i_phase >= r_rise) && (i_phase < r_fall);
    assign o_level  = r_level;

    always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_rise  <= '0;
            r_fall  <= '0;
            r_level <= 1'b0;
        end else begin
            if (i_cfg_we) begin
                r_rise <= i_cfg_wdata[CNT_W-1:0];
                r_fall <= i_cfg_wdata[FALL_LSB +: CNT_W];
            end
            r_level <= (i_run_en & w_window) ^ i_inv;
        end
    end

endmodule

// File: rtl/out_pattern_sequencer.sv
// rtl/out_pattern_sequencer.sv - frame sequencer driving eight windowed output channels
// Optional per-channel output inversion mask at address 10 when OUT_SEQ_POLARITY_EN is defined.
module out_pattern_sequencer
    import out_seq_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int NUM_CH = 8
) (
    input  logic             clk_in_500MHz,
    input  logic             reset_n,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             out_clk_p,
    output logic             out_clk_short,
    output logic             out_clk_d,
    output logic             out_clk_dac,
    output logic             out_clk_dac_p,
    output logic             out_clk_dac_d,
    output logic             out_RST,
    output logic             out_STIM
);

    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] TWO = 2;

    seq_state_t        r_state;
    logic [CNT_W-1:0]  r_phase;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_fcount;
    logic              r_busy;
    logic              r_done;
    logic              r_cfg_err;

    logic              w_cfg_ok;
    logic              w_frame_end;
    logic              w_last_frame;
    logic              w_run_en;
    logic [NUM_CH-1:0] w_ch_we;
    logic [NUM_CH-1:0] w_level;
    logic [NUM_CH-1:0] w_pol;

`ifdef OUT_SEQ_POLARITY_EN
    logic [NUM_CH-1:0] r_pol;
    assign w_pol = r_pol;
`else
    assign w_pol = '0;
`endif

    assign w_cfg_ok     = cfg_we && (r_state == IDLE);
    assign w_frame_end  = (r_phase == r_period - ONE);
    assign w_last_frame = w_frame_end && (r_fcount != '0) && (r_frame_cnt == r_fcount - ONE);
    // DRAIN parks at phase 0 once its frame has wrapped; that cycle must not drive
    assign w_run_en     = (r_state == RUN) || ((r_state == DRAIN) && (r_phase != '0));

    always_ff @(posedge clk_in_500MHz or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_phase     <= '0;
            r_frame_cnt <= '0;
            r_period    <= '0;
            r_fcount    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
`ifdef OUT_SEQ_POLARITY_EN
            r_pol       <= '0;
`endif
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= cfg_we && (r_state != IDLE);
            if (w_cfg_ok) begin
                case (cfg_addr)
                    ADDR_PERIOD: r_period <= cfg_wdata[CNT_W-1:0];
                    ADDR_FCOUNT: r_fcount <= cfg_wdata[CNT_W-1:0];
`ifdef OUT_SEQ_POLARITY_EN
                    ADDR_POL:    r_pol    <= cfg_wdata[NUM_CH-1:0];
`endif
                    default: ;
                endcase
            end
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        if (r_period < TWO) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_state     <= ARM;
                            r_busy      <= 1'b1;
                            r_phase     <= '0;
                            r_frame_cnt <= '0;
                        end
                    end
                end
                ARM: r_state <= RUN;
                RUN: begin
                    r_phase <= w_frame_end ? '0 : r_phase + ONE;
                    if (w_frame_end) r_frame_cnt <= r_frame_cnt + ONE;
                    if (stop || w_last_frame) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (r_phase == '0) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_phase <= w_frame_end ? '0 : r_phase + ONE;
                        if (w_frame_end) r_frame_cnt <= r_frame_cnt + ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_ch_we[g] = w_cfg_ok && (cfg_addr == ADDR_CH0 + 4'(g));

        out_seq_channel #(.CNT_W(CNT_W)) u_ch (
            .clk_in_500MHz (clk_in_500MHz),
            .reset_n       (reset_n),
            .i_cfg_we      (w_ch_we[g]),
            .i_cfg_wdata   (cfg_wdata),
            .i_phase       (r_phase),
            .i_run_en      (w_run_en),
            .i_inv         (w_pol[g]),
            .o_level       (w_level[g])
        );
    end

    assign cfg_err       = r_cfg_err;
    assign busy          = r_busy;
    assign done          = r_done;
    assign frame_cnt     = r_frame_cnt;
    assign out_clk_p     = w_level[CH_CLK_P];
    assign out_clk_short = w_level[CH_CLK_SHORT];
    assign out_clk_d     = w_level[CH_CLK_D];
    assign out_clk_dac   = w_level[CH_CLK_DAC];
    assign out_clk_dac_p = w_level[CH_CLK_DAC_P];
    assign out_clk_dac_d = w_level[CH_CLK_DAC_D];
    assign out_RST       = w_level[CH_RST];
    assign out_STIM      = w_level[CH_STIM];

endmodule

// File: tb/tb_out_pattern_sequencer.sv
// tb/tb_out_pattern_sequencer.sv - self-checking bench with a frame-arithmetic reference model
`timescale 1ns/1ps
module tb_out_pattern_sequencer;

`ifdef OUT_SEQ_POLARITY_EN
    localparam bit POL_EN = 1'b1;
`else
    localparam bit POL_EN = 1'b0;
`endif

    logic        clk_in_500MHz = 1'b0;
    logic        reset_n;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_err;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic [15:0] frame_cnt;
    logic        out_clk_p, out_clk_short, out_clk_d, out_clk_dac;
    logic        out_clk_dac_p, out_clk_dac_d, out_RST, out_STIM;
    logic [7:0]  w_out;

    int          n_vec  = 0;
    int          n_fail = 0;
    int          rise_a [8];
    int          fall_a [8];
    logic [7:0]  exp_pol;

    out_pattern_sequencer dut (
        .clk_in_500MHz (clk_in_500MHz),
        .reset_n       (reset_n),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .cfg_err       (cfg_err),
        .start         (start),
        .stop          (stop),
        .busy          (busy),
        .done          (done),
        .frame_cnt     (frame_cnt),
        .out_clk_p     (out_clk_p),
        .out_clk_short (out_clk_short),
        .out_clk_d     (out_clk_d),
        .out_clk_dac   (out_clk_dac),
        .out_clk_dac_p (out_clk_dac_p),
        .out_clk_dac_d (out_clk_dac_d),
        .out_RST       (out_RST),
        .out_STIM      (out_STIM)
    );

    assign w_out = {out_STIM, out_RST, out_clk_dac_d, out_clk_dac_p,
                    out_clk_dac, out_clk_d, out_clk_short, out_clk_p};

    always #5 clk_in_500MHz = ~clk_in_500MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_levels(input int ph);
        logic [7:0] v;
        for (int c = 0; c < 8; c++)
            v[c] = (rise_a[c] < fall_a[c]) && (ph >= rise_a[c]) && (ph < fall_a[c]);
        return v;
    endfunction

    task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input logic exp_err, input string tag);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk_in_500MHz);
        @(negedge clk_in_500MHz);
        cfg_we = 1'b0;
        check(tag, {31'b0, cfg_err}, {31'b0, exp_err});
    endtask

    task automatic set_window(input int c, input int r, input int f);
        rise_a[c] = r;
        fall_a[c] = f;
        cfg_write(4'(c), {16'(f), 16'(r)}, 1'b0, "cfg_ch");
    endtask

    // A stop sampled in frame F is equivalent to a burst of F+1 frames.
    task automatic run_seq(input string tag, input int p, input int n, input int stop_f,
                           input int stop_ph, input bit poke);
        int neff, stop_edge, fc;
        logic [7:0] exp_out;
        neff      = (stop_f >= 0) ? stop_f + 1 : n;
        stop_edge = (stop_f >= 0) ? 2 + stop_f * p + stop_ph : -1;
        start = 1'b1;
        @(posedge clk_in_500MHz);
        for (int k = 0; k <= neff * p + 4; k++) begin
            if (k > 0) @(posedge clk_in_500MHz);
            @(negedge clk_in_500MHz);
            start = 1'b0;
            exp_out = (k >= 2 && k <= neff * p + 1) ? (exp_levels((k - 2) % p) ^ exp_pol) : exp_pol;
            fc = (k == 0) ? 0 : (k - 1) / p;
            if (fc > neff) fc = neff;
            check({tag, "/out"},     {24'b0, w_out}, {24'b0, exp_out});
            check({tag, "/busy"},    {31'b0, busy},  {31'b0, (k <= neff * p + 1)});
            check({tag, "/done"},    {31'b0, done},  {31'b0, (k == neff * p + 2)});
            check({tag, "/fcnt"},    {16'b0, frame_cnt}, fc);
            check({tag, "/cfg_err"}, {31'b0, cfg_err},   {31'b0, (poke && k == 4)});
            cfg_we    = poke && (k == 3);
            cfg_addr  = 4'd8;
            cfg_wdata = 32'd5;
            stop      = (k + 1 == stop_edge);
        end
        cfg_we = 1'b0;
        stop   = 1'b0;
    endtask

    initial begin
        int p, n, sf, sp;
        reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; stop = 1'b0; exp_pol = 8'h00;
        for (int c = 0; c < 8; c++) begin rise_a[c] = 0; fall_a[c] = 0; end
        repeat (3) @(negedge clk_in_500MHz);
        check("rst/out",  {24'b0, w_out},     32'h0);
        check("rst/busy", {31'b0, busy},      32'h0);
        check("rst/done", {31'b0, done},      32'h0);
        check("rst/fcnt", {16'b0, frame_cnt}, 32'h0);
        check("rst/err",  {31'b0, cfg_err},   32'h0);
        reset_n = 1'b1;
        @(negedge clk_in_500MHz);

        // period resets to 0, so a start is rejected
        start = 1'b1;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        start = 1'b0;
        check("start_p0/err",  {31'b0, cfg_err}, 32'h1);
        check("start_p0/busy", {31'b0, busy},    32'h0);

        set_window(0, 2, 5);
        set_window(1, 4, 4);
        set_window(2, 6, 3);
        set_window(3, $urandom_range(0, 8), 20);
        for (int c = 4; c < 8; c++) set_window(c, $urandom_range(0, 14), $urandom_range(0, 14));
        cfg_write(4'd8, 32'd10, 1'b0, "cfg_period");
        cfg_write(4'd9, 32'd3, 1'b0, "cfg_fcount");
        cfg_write(4'd12, 32'hFFFF_FFFF, 1'b0, "cfg_addr12");
        run_seq("burst", 10, 3, -1, 0, 1'b1);

        cfg_write(4'd8, 32'd8, 1'b0, "cfg_period");
        cfg_write(4'd9, 32'd0, 1'b0, "cfg_fcount");
        run_seq("stop", 8, 0, 5, 3, 1'b1);

        for (int it = 0; it < 4; it++) begin
            for (int c = 4; c < 8; c++) set_window(c, $urandom_range(0, 14), $urandom_range(0, 14));
            p = $urandom_range(2, 12);
            cfg_write(4'd8, 32'(p), 1'b0, "cfg_period");
            if ($urandom_range(0, 1) == 1) begin
                n = $urandom_range(1, 3);
                cfg_write(4'd9, 32'(n), 1'b0, "cfg_fcount");
                run_seq("rand_burst", p, n, -1, 0, (n * p >= 3));
            end else begin
                sf = $urandom_range(0, 2);
                sp = $urandom_range(0, p - 1);
                cfg_write(4'd9, 32'd0, 1'b0, "cfg_fcount");
                run_seq("rand_stop", p, 0, sf, sp, ((sf + 1) * p >= 3));
            end
        end

        cfg_write(4'd10, 32'h80, 1'b0, "cfg_pol");
        exp_pol = POL_EN ? 8'h80 : 8'h00;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        check("pol_idle/out", {24'b0, w_out}, {24'b0, exp_pol});
        cfg_write(4'd8, 32'd6, 1'b0, "cfg_period");
        cfg_write(4'd9, 32'd2, 1'b0, "cfg_fcount");
        run_seq("pol", 6, 2, -1, 0, 1'b1);
        cfg_write(4'd10, 32'h00, 1'b0, "cfg_pol");
        exp_pol = 8'h00;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        check("pol_clr/out", {24'b0, w_out}, 32'h0);

        cfg_write(4'd8, 32'd1, 1'b0, "cfg_period");
        start = 1'b1;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        start = 1'b0;
        check("start_p1/err",  {31'b0, cfg_err}, 32'h1);
        check("start_p1/busy", {31'b0, busy},    32'h0);
        @(negedge clk_in_500MHz);
        check("start_p1/pulse", {31'b0, cfg_err}, 32'h0);
        check("start_p1/idle",  {31'b0, busy},    32'h0);

        cfg_write(4'd8, 32'd10, 1'b0, "cfg_period");
        start = 1'b1; stop = 1'b1;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        start = 1'b0; stop = 1'b0;
        @(negedge clk_in_500MHz);
        check("start_stop/busy", {31'b0, busy},    32'h0);
        check("start_stop/err",  {31'b0, cfg_err}, 32'h0);

        cfg_write(4'd9, 32'd0, 1'b0, "cfg_fcount");
        start = 1'b1;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        start = 1'b0;
        repeat (14) @(negedge clk_in_500MHz);
        check("mid_run/busy", {31'b0, busy}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check("arst/out",  {24'b0, w_out},     32'h0);
        check("arst/busy", {31'b0, busy},      32'h0);
        check("arst/fcnt", {16'b0, frame_cnt}, 32'h0);
        check("arst/done", {31'b0, done},      32'h0);
        @(negedge clk_in_500MHz);
        reset_n = 1'b1;
        @(negedge clk_in_500MHz);
        check("post_rst/done", {31'b0, done}, 32'h0);
        for (int c = 0; c < 8; c++) begin rise_a[c] = 0; fall_a[c] = 0; end
        start = 1'b1;
        @(posedge clk_in_500MHz); @(negedge clk_in_500MHz);
        start = 1'b0;
        check("post_rst/period0", {31'b0, cfg_err}, 32'h1);
        cfg_write(4'd8, 32'd6, 1'b0, "cfg_period");
        cfg_write(4'd9, 32'd1, 1'b0, "cfg_fcount");
        run_seq("post_rst", 6, 1, -1, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
